// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key filter: decoder states and the
// protocol byte values the decoder treats specially.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  // Keyboard status/handshake bytes that never represent a key.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_FE) ||
           (b == BYTE_EE) || (b == BYTE_00) || (b == BYTE_FF);
  endfunction

endpackage

// File: rtl/ps2_held_table.sv
// Small table of currently held make codes; lookup, insert (first free slot,
// else round-robin overwrite) and clear-by-code.
module ps2_held_table #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_code,
  input  logic       i_insert,
  input  logic       i_clear,
  output logic       o_hit
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0] r_valid;
  logic [7:0]       r_code [DEPTH];
  logic [PW-1:0]    r_ptr;

  logic             w_hit;
  logic             w_free_found;
  logic [PW-1:0]    w_free_idx;

  always_comb begin
    w_hit        = 1'b0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_code[i] == i_code)) w_hit = 1'b1;
    end
    // Scan downward so the lowest free slot wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = PW'(i);
      end
    end
  end

  assign o_hit = w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else begin
      if (i_insert) begin
        if (w_free_found) begin
          r_valid[w_free_idx] <= 1'b1;
          r_code[w_free_idx]  <= i_code;
        end else begin
          r_valid[r_ptr] <= 1'b1;
          r_code[r_ptr]  <= i_code;
          r_ptr          <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
      end
      if (i_clear) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && (r_code[i] == i_code)) r_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_filter.sv
// PS/2 scancode filter: decodes make/break/extended prefixes, drops extended
// keys and status bytes. Define PS2_KEY_FILTER_REPEAT_EN to suppress typematic repeats.
module ps2_key_filter
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int HELD_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       key_release,
  output logic [1:0] dbg_state
);

  // rx_valid is a one-cycle strobe qualifying rx_byte with no backpressure;
  // key_valid/key_release are one-cycle pulses, key is held between them.

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t      r_state;
  ps2_state_t      w_next_state;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_key;
  logic            r_key_valid;
  logic            r_key_release;

  logic            w_expired;
  logic            w_is_make;
  logic            w_emit_make;
  logic            w_emit_break;
  logic            w_hit;

  assign w_expired = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_is_make    = 1'b0;
    w_emit_break = 1'b0;
    if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_byte == BYTE_E0)      w_next_state = ST_EXT;
          else if (rx_byte == BYTE_F0) w_next_state = ST_BRK;
          else if (!is_ignored(rx_byte)) w_is_make = 1'b1;
        end
        ST_BRK: begin
          w_emit_break = 1'b1;
          w_next_state = ST_IDLE;
        end
        ST_EXT: begin
          w_next_state = (rx_byte == BYTE_F0) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end else if ((r_state != ST_IDLE) && w_expired) begin
      w_next_state = ST_IDLE;
    end
  end

  // Saturating count of cycles since the last byte.
  always_ff @(posedge clk) begin
    if (rst || rx_valid) begin
      r_to_cnt <= '0;
    end else if (!w_expired) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

`ifdef PS2_KEY_FILTER_REPEAT_EN
  ps2_held_table #(
    .DEPTH (HELD_DEPTH)
  ) u_held_table (
    .clk      (clk),
    .rst      (rst),
    .i_code   (rx_byte),
    .i_insert (w_emit_make),
    .i_clear  (w_emit_break),
    .o_hit    (w_hit)
  );
`else
  logic w_unused_depth;
  assign w_unused_depth = (HELD_DEPTH > 0);
  assign w_hit          = 1'b0;
`endif

  assign w_emit_make = w_is_make && !w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key         <= 8'h00;
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_key_valid   <= w_emit_make;
      r_key_release <= w_emit_break;
      if (w_emit_make || w_emit_break) r_key <= rx_byte;
    end
  end

  assign key         = r_key;
  assign key_valid   = r_key_valid;
  assign key_release = r_key_release;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_key_filter.sv
// Scoreboard bench for ps2_key_filter: directed byte sequences push expected
// pulses into a queue, a negedge monitor pops and compares each pulse.
module tb_ps2_key_filter;

  localparam int TO = 16;
`ifdef PS2_KEY_FILTER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] key;
  logic       key_valid;
  logic       key_release;
  logic [1:0] dbg_state;

  ps2_key_filter #(
    .TIMEOUT_CYCLES (TO),
    .HELD_DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .key         (key),
    .key_valid   (key_valid),
    .key_release (key_release),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // {release, code}
  logic [8:0] exp_q[$];
  logic [8:0] got_p;
  logic [8:0] exp_p;
  logic [7:0] last_key = 8'h00;
  logic       strobe_at_edge = 1'b0;
  logic       rst_at_edge = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // driver tasks: called at a negedge, return at a later negedge
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mk(input logic [7:0] b, input bit emitted);
    if (emitted) exp_q.push_back({1'b0, b});
    send(b);
  endtask

  task automatic brk(input logic [7:0] b);
    send(8'hF0);
    exp_q.push_back({1'b1, b});
    send(b);
  endtask

  always @(posedge clk) begin
    strobe_at_edge <= rx_valid;
    rst_at_edge    <= rst;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_at_edge) begin
      check("reset_outputs", {22'd0, key_valid, key_release, key}, 32'd0);
      last_key = 8'h00;
    end else if (key_valid || key_release) begin
      got_p = {key_release, key};
      check("pulse_exclusive", {31'd0, key_valid && key_release}, 32'd0);
      check("latency", {31'd0, strobe_at_edge}, 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got %0h expected none (t=%0t)", got_p, $time);
      end else begin
        exp_p = exp_q.pop_front();
        check("pulse", {23'd0, got_p}, {23'd0, exp_p});
        last_key = exp_p[7:0];
      end
    end else begin
      check("key_hold", {24'd0, key}, {24'd0, last_key});
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    idle(2);

    // typematic repeat, back-to-back strobes
    mk(8'h16, 1'b1);
    mk(8'h16, !REP);
    mk(8'h16, !REP);
    brk(8'h16);
    idle(2);

    // extended codes never reach key
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    mk(8'h75, 1'b1);
    brk(8'h75);
    idle(2);

    // table fill and round-robin eviction
    mk(8'h16, 1'b1); mk(8'h1E, 1'b1); mk(8'h26, 1'b1); mk(8'h25, 1'b1);
    mk(8'h2E, 1'b1); mk(8'h16, 1'b1);
    mk(8'h1E, 1'b1);
    mk(8'h25, !REP);
    brk(8'h2E); brk(8'h16); brk(8'h1E); brk(8'h25);
    brk(8'h26);
    idle(2);

    // status bytes ignored
    send(8'hAA); mk(8'h72, 1'b1); send(8'hFA); send(8'h00);
    send(8'hFE); send(8'hEE); send(8'hFF);
    brk(8'h72);
    idle(2);

    // timeout in BRK: expired, then byte arriving on the expiry cycle
    send(8'hF0); idle(TO);
    mk(8'h45, 1'b1);
    send(8'hF0); idle(TO - 1);
    exp_q.push_back({1'b1, 8'h45});
    send(8'h45);
    idle(2);
    check("idle_after_release", {30'd0, dbg_state}, 32'd0);

    // timeout in EXT
    send(8'hE0); idle(TO);
    mk(8'h3C, 1'b1);
    brk(8'h3C);
    send(8'hE0); idle(TO - 1);
    send(8'h3C);
    mk(8'h3C, 1'b1);
    brk(8'h3C);
    idle(2);

    // reset mid-sequence abandons prefix and clears the table
    mk(8'h4A, 1'b1);
    send(8'hE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mk(8'h69, 1'b1);
    mk(8'h4A, 1'b1);
    brk(8'h69);
    brk(8'h4A);

    idle(5);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_filter.md
PS2_KEY_FILTER -- requirements
Module: ps2_key_filter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning idle cycles after which a partial prefix sequence is abandoned.
REQ-002 SHALL have parameter HELD_DEPTH, default 4, meaning number of held-key table entries.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_byte  input  8  raw byte from the PS/2 receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_byte.
REQ-007 SHALL have port key  output  8  filtered non-extended scancode; feeds the key-to-number stage.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse: key holds a new press.
REQ-009 SHALL have port key_release  output  1  one-cycle pulse: key holds a released code.

Function
REQ-010 SHALL run an FSM with states IDLE, BRK (F0 seen), EXT (E0 seen) and EXT_BRK (E0 F0 seen).
REQ-011 In IDLE: E0 -> EXT; F0 -> BRK; AA, FA, FE, EE, 00 and FF ignored, stay IDLE; any other byte is a make code, stay IDLE.
REQ-012 In BRK: any byte is a break code -> IDLE; key_release pulses with key = that byte; its held-table entry is cleared.
REQ-013 In EXT: F0 -> EXT_BRK; any other byte is discarded -> IDLE. Extended codes never reach key (E0 75 must not alias numpad 8).
REQ-014 In EXT_BRK: any byte is discarded -> IDLE; no output pulse.
REQ-015 A make code not present in the held table SHALL pulse key_valid with key = byte exactly one cycle after the rx_valid cycle (latency 1), and be inserted into the table.
REQ-016 A make code already present in the held table (typematic repeat) SHALL be suppressed, with no pulse.
REQ-017 On a new make with the table full, the make SHALL still be emitted and SHALL overwrite the entry at a round-robin replacement pointer, which then advances modulo HELD_DEPTH.
REQ-018 A break code absent from the table SHALL still pulse key_release.
REQ-019 key_valid and key_release SHALL never be high in the same cycle; key SHALL hold its last value between pulses.
REQ-020 A timeout counter SHALL reset on every rx_valid; in BRK, EXT or EXT_BRK, after TIMEOUT_CYCLES cycles without rx_valid, the FSM SHALL return to IDLE with no output.
REQ-021 If rx_valid arrives in the same cycle the timeout expires, the byte SHALL win and be processed in the current state.
REQ-022 rx_valid strobes on consecutive cycles SHALL each be processed; no byte is dropped.

Reset
REQ-023 While rst is high: FSM = IDLE, key = 8'h00, key_valid = 0, key_release = 0, all table entries invalid, replacement pointer = 0, timeout counter = 0.
REQ-024 rst asserted mid-sequence SHALL abandon the sequence; the next byte after release is decoded from IDLE.

Configuration
REQ-025 Macro PS2_KEY_FILTER_REPEAT_EN defined: the held table and typematic suppression (REQ-015 to REQ-017) SHALL be built.
REQ-026 Macro PS2_KEY_FILTER_REPEAT_EN undefined: no table SHALL be built, and every make SHALL pulse key_valid; break behaviour is unchanged.

Structure
REQ-027 A shared package ps2_pkg SHALL hold the FSM state enum and the byte constants E0, F0, AA, FA, FE, EE, 00 and FF.
REQ-028 The held table SHALL be a sub-module ps2_held_table (lookup, insert, clear, round-robin pointer), instantiated only under PS2_KEY_FILTER_REPEAT_EN.

Verification
REQ-029 Bytes 16, 16, 16 (typematic), then F0 16 -> one key_valid with key=16, then one key_release with key=16; with the macro undefined, three key_valid pulses.
REQ-030 Bytes E0 75, then E0 F0 75 -> no key_valid or key_release; then byte 75 -> key_valid with key=75.
REQ-031 Makes 16, 1E, 26, 25, 2E, then 16 -> six key_valid pulses (entry 16 evicted by 2E).
REQ-032 Byte F0, then no rx_valid for TIMEOUT_CYCLES cycles, then 45 -> key_valid with key=45, no release.
REQ-033 Byte E0, rst pulsed for 1 cycle, then 69 -> outputs 0 during rst; key_valid with key=69 one cycle after the 69 strobe.
REQ-034 Bytes AA, FA and 00 interleaved with make 72 -> only one key_valid, with key=72.
